// File: rtl/soc_bus_matrix.sv
// Multi-master / multi-slave memory-bus crossbar: per-master address decode,
// per-slave round-robin arbiter with timeout watchdog, unmapped-address error responder.
module soc_bus_matrix #(
  parameter int                        MASTER_COUNT          = 3,
  parameter int                        SLAVE_COUNT           = 7,
  parameter logic [32*SLAVE_COUNT-1:0] SLAVE_START_ADDRESSES = '0,
  parameter logic [32*SLAVE_COUNT-1:0] SLAVE_END_ADDRESSES   = '0,
  parameter int                        TIMEOUT_CYCLES        = 256
) (
  input  logic                       clk,
  input  logic                       res,
  input  logic [MASTER_COUNT-1:0]    m_req,
  input  logic [32*MASTER_COUNT-1:0] m_addr,
  input  logic [MASTER_COUNT-1:0]    m_we,
  input  logic [4*MASTER_COUNT-1:0]  m_wmask,
  input  logic [32*MASTER_COUNT-1:0] m_wdata,
  output logic [MASTER_COUNT-1:0]    m_ack,
  output logic [MASTER_COUNT-1:0]    m_err,
  output logic [32*MASTER_COUNT-1:0] m_rdata,
  output logic [SLAVE_COUNT-1:0]     s_req,
  output logic [32*SLAVE_COUNT-1:0]  s_addr,
  output logic [SLAVE_COUNT-1:0]     s_we,
  output logic [4*SLAVE_COUNT-1:0]   s_wmask,
  output logic [32*SLAVE_COUNT-1:0]  s_wdata,
  input  logic [SLAVE_COUNT-1:0]     s_ack,
  input  logic [32*SLAVE_COUNT-1:0]  s_rdata,
  output logic [SLAVE_COUNT-1:0]     s_abort
);
  // state | meaning
  // IDLE  | slave free, arbitrate among requesting masters from rr_ptr
  // BUSY  | slave owned by gnt, forwarding until s_ack or timeout
  localparam int MW = (MASTER_COUNT > 1) ? $clog2(MASTER_COUNT) : 1;
  localparam int SW = (SLAVE_COUNT > 1) ? $clog2(SLAVE_COUNT) : 1;
  localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT_CYCLES);

  typedef enum logic {IDLE, BUSY} arb_state_e;

  arb_state_e              state_q  [SLAVE_COUNT];
  arb_state_e              state_d  [SLAVE_COUNT];
  logic [MW-1:0]           gnt_q    [SLAVE_COUNT];
  logic [MW-1:0]           gnt_d    [SLAVE_COUNT];
  logic [MW-1:0]           rr_ptr_q [SLAVE_COUNT];
  logic [MW-1:0]           rr_ptr_d [SLAVE_COUNT];
  logic [15:0]             cnt_q    [SLAVE_COUNT];
  logic [15:0]             cnt_d    [SLAVE_COUNT];
  logic [MASTER_COUNT-1:0] unm_q, unm_d;

  logic [MASTER_COUNT-1:0] hit;
  logic [SW-1:0]           sel [MASTER_COUNT];
  logic [SLAVE_COUNT-1:0]  timeout;
  logic [MASTER_COUNT-1:0] granted;

  // Descending scan so the lowest matching slave index wins on overlap.
  always_comb begin
    for (int m = 0; m < MASTER_COUNT; m++) begin
      hit[m] = 1'b0;
      sel[m] = '0;
      for (int s = SLAVE_COUNT - 1; s >= 0; s--) begin
        if (m_addr[32*m +: 32] >= SLAVE_START_ADDRESSES[32*s +: 32] &&
            m_addr[32*m +: 32] <= SLAVE_END_ADDRESSES[32*s +: 32]) begin
          hit[m] = 1'b1;
          sel[m] = SW'(s);
        end
      end
    end
  end

  always_comb begin
    granted = '0;
    for (int s = 0; s < SLAVE_COUNT; s++) begin
      timeout[s] = (TIMEOUT_CYCLES != 0) && (state_q[s] == BUSY) && (cnt_q[s] == TIMEOUT_VAL);
      if (state_q[s] == BUSY) granted[gnt_q[s]] = 1'b1;
    end
  end

  always_comb begin
    logic          found;
    logic [MW-1:0] cand;
    int            idx;
    found = 1'b0;
    cand  = '0;
    idx   = 0;
    for (int s = 0; s < SLAVE_COUNT; s++) begin
      state_d[s]  = state_q[s];
      gnt_d[s]    = gnt_q[s];
      rr_ptr_d[s] = rr_ptr_q[s];
      cnt_d[s]    = cnt_q[s];
      found       = 1'b0;
      if (state_q[s] == BUSY) begin
        if (timeout[s] || s_ack[s]) state_d[s] = IDLE;
        else                        cnt_d[s]   = cnt_q[s] + 16'd1;
      end else begin
        for (int k = 0; k < MASTER_COUNT; k++) begin
          idx = int'(rr_ptr_q[s]) + k;
          if (idx >= MASTER_COUNT) idx = idx - MASTER_COUNT;
          cand = MW'(idx);
          if (!found && m_req[cand] && !granted[cand] && hit[cand] && sel[cand] == SW'(s)) begin
            found       = 1'b1;
            state_d[s]  = BUSY;
            gnt_d[s]    = cand;
            cnt_d[s]    = '0;
            rr_ptr_d[s] = (idx == MASTER_COUNT - 1) ? '0 : MW'(idx + 1);
          end
        end
      end
    end
    // The flag blocks its own re-arm during the ack cycle of the same request.
    unm_d = m_req & ~hit & ~unm_q;
  end

  always_comb begin
    m_ack   = '0;
    m_err   = '0;
    m_rdata = '0;
    s_req   = '0;
    s_addr  = '0;
    s_we    = '0;
    s_wmask = '0;
    s_wdata = '0;
    s_abort = '0;
    for (int s = 0; s < SLAVE_COUNT; s++) begin
      if (state_q[s] == BUSY) begin
        if (timeout[s]) begin
          s_abort[s]        = 1'b1;
          m_ack[gnt_q[s]]   = 1'b1;
          m_err[gnt_q[s]]   = 1'b1;
        end else begin
          s_req[s]            = 1'b1;
          s_addr[32*s +: 32]  = m_addr[32*gnt_q[s] +: 32];
          s_we[s]             = m_we[gnt_q[s]];
          s_wmask[4*s +: 4]   = m_wmask[4*gnt_q[s] +: 4];
          s_wdata[32*s +: 32] = m_wdata[32*gnt_q[s] +: 32];
          if (s_ack[s]) begin
            m_ack[gnt_q[s]]              = 1'b1;
            m_rdata[32*gnt_q[s] +: 32]   = s_rdata[32*s +: 32];
          end
        end
      end
    end
    for (int m = 0; m < MASTER_COUNT; m++) begin
      if (unm_q[m]) begin
        m_ack[m] = 1'b1;
        m_err[m] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      for (int s = 0; s < SLAVE_COUNT; s++) begin
        state_q[s]  <= IDLE;
        gnt_q[s]    <= '0;
        rr_ptr_q[s] <= '0;
        cnt_q[s]    <= '0;
      end
      unm_q <= '0;
    end else begin
      for (int s = 0; s < SLAVE_COUNT; s++) begin
        state_q[s]  <= state_d[s];
        gnt_q[s]    <= gnt_d[s];
        rr_ptr_q[s] <= rr_ptr_d[s];
        cnt_q[s]    <= cnt_d[s];
      end
      unm_q <= unm_d;
    end
  end

endmodule

// File: tb/tb_soc_bus_matrix.sv
// Bench for soc_bus_matrix: directed scenarios plus random traffic, every cycle
// compared against a transaction-level ownership model of the crossbar.
module tb_soc_bus_matrix;
  localparam int M  = 3;
  localparam int S  = 7;
  localparam int TO = 4;
  localparam logic [32*S-1:0] START_MAP = {32'h1000_0000, 32'h1000_0000, 32'h0400_0000,
    32'h0300_0000, 32'h0200_0000, 32'h0100_0000, 32'h0000_0000};
  localparam logic [32*S-1:0] END_MAP   = {32'h2FFF_FFFF, 32'h1FFF_FFFF, 32'h0400_00FF,
    32'h0300_00FF, 32'h0200_00FF, 32'h0100_00FF, 32'h0000_0FFF};

  logic clk, res;
  logic [M-1:0] m_req, m_we, m_ack, m_err;
  logic [32*M-1:0] m_addr, m_wdata, m_rdata;
  logic [4*M-1:0] m_wmask;
  logic [S-1:0] s_req, s_we, s_ack, s_abort;
  logic [32*S-1:0] s_addr, s_wdata, s_rdata;
  logic [4*S-1:0] s_wmask;

  soc_bus_matrix #(
    .MASTER_COUNT(M), .SLAVE_COUNT(S),
    .SLAVE_START_ADDRESSES(START_MAP), .SLAVE_END_ADDRESSES(END_MAP),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .res(res),
    .m_req(m_req), .m_addr(m_addr), .m_we(m_we), .m_wmask(m_wmask), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
    .s_req(s_req), .s_addr(s_addr), .s_we(s_we), .s_wmask(s_wmask), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_rdata(s_rdata), .s_abort(s_abort)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: which master owns each slave (-1 = free), cycles since grant,
  // next preferred master, and pending unmapped-error per master.
  int owner [S];
  int age   [S];
  int rr    [S];
  int lat   [S];
  int flat  [S];
  bit unm   [M];

  bit spur_en, rd_fixed;
  logic [31:0] rd_val;

  logic [M-1:0] e_m_ack, e_m_err, prev_ack;
  logic [32*M-1:0] e_m_rdata;
  logic [S-1:0] e_s_req, e_s_we, e_s_abort;
  logic [32*S-1:0] e_s_addr, e_s_wdata;
  logic [4*S-1:0] e_s_wmask;

  logic [M-1:0] snap_m_ack, snap_m_err;
  logic [32*M-1:0] snap_m_rdata;
  logic [S-1:0] snap_s_req, snap_s_abort, snap_s_we;
  logic [32*S-1:0] snap_s_addr;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int s = 0; s < S; s++)
      if (a >= START_MAP[32*s +: 32] && a <= END_MAP[32*s +: 32]) return s;
    return -1;
  endfunction

  function automatic int rand_lat();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(4, 6));
    return int'($urandom_range(0, 3));
  endfunction

  function automatic logic [31:0] pick_addr();
    int s;
    logic [31:0] lo, hi;
    s  = int'($urandom_range(0, S - 1));
    lo = START_MAP[32*s +: 32];
    hi = END_MAP[32*s +: 32];
    case ($urandom_range(0, 7))
      0: return lo;
      1: return hi;
      2: return hi + 32'd1;
      3: return lo - 32'd1;
      4: return 32'hF000_0000;
      5: return $urandom();
      default: return lo + ($urandom() % (hi - lo + 32'd1));
    endcase
  endfunction

  task automatic model_reset();
    for (int s = 0; s < S; s++) begin
      owner[s] = -1; age[s] = 0; rr[s] = 0; lat[s] = 0;
    end
    for (int m = 0; m < M; m++) unm[m] = 1'b0;
  endtask

  task automatic model_outputs();
    int o;
    e_m_ack = '0; e_m_err = '0; e_m_rdata = '0;
    e_s_req = '0; e_s_we = '0; e_s_abort = '0;
    e_s_addr = '0; e_s_wdata = '0; e_s_wmask = '0;
    for (int s = 0; s < S; s++) begin
      if (owner[s] >= 0) begin
        o = owner[s];
        if (TO != 0 && age[s] == TO) begin
          e_s_abort[s] = 1'b1;
          e_m_ack[o] = 1'b1;
          e_m_err[o] = 1'b1;
        end else begin
          e_s_req[s] = 1'b1;
          e_s_addr[32*s +: 32]  = m_addr[32*o +: 32];
          e_s_we[s]             = m_we[o];
          e_s_wmask[4*s +: 4]   = m_wmask[4*o +: 4];
          e_s_wdata[32*s +: 32] = m_wdata[32*o +: 32];
          if (s_ack[s]) begin
            e_m_ack[o] = 1'b1;
            e_m_rdata[32*o +: 32] = s_rdata[32*s +: 32];
          end
        end
      end
    end
    for (int m = 0; m < M; m++)
      if (unm[m]) begin
        e_m_ack[m] = 1'b1;
        e_m_err[m] = 1'b1;
      end
  endtask

  task automatic model_advance();
    bit taken [M];
    bit unm_n [M];
    if (res) begin
      model_reset();
      return;
    end
    for (int m = 0; m < M; m++) taken[m] = 1'b0;
    for (int s = 0; s < S; s++) if (owner[s] >= 0) taken[owner[s]] = 1'b1;
    for (int m = 0; m < M; m++)
      unm_n[m] = m_req[m] && decode(m_addr[32*m +: 32]) < 0 && !unm[m];
    for (int s = 0; s < S; s++) begin
      if (owner[s] >= 0) begin
        if ((TO != 0 && age[s] == TO) || s_ack[s]) owner[s] = -1;
        else age[s]++;
      end else begin
        for (int k = 0; k < M; k++) begin
          int c;
          c = (rr[s] + k) % M;
          if (m_req[c] && !taken[c] && decode(m_addr[32*c +: 32]) == s) begin
            owner[s] = c;
            age[s]   = 0;
            rr[s]    = (c + 1) % M;
            lat[s]   = (flat[s] >= 0) ? flat[s] : rand_lat();
            break;
          end
        end
      end
    end
    for (int m = 0; m < M; m++) unm[m] = unm_n[m];
  endtask

  task automatic drive_slaves();
    for (int s = 0; s < S; s++) begin
      s_ack[s] = 1'b0;
      s_rdata[32*s +: 32] = $urandom();
      if (owner[s] >= 0) begin
        if (age[s] == lat[s]) begin
          s_ack[s] = 1'b1;
          if (rd_fixed) s_rdata[32*s +: 32] = rd_val;
        end
      end else if (spur_en && $urandom_range(0, 15) == 0) begin
        s_ack[s] = 1'b1;
      end
    end
  endtask

  task automatic new_req(input int m, input logic [31:0] a, input logic we);
    m_req[m] = 1'b1;
    m_addr[32*m +: 32] = a;
    m_we[m] = we;
    m_wmask[4*m +: 4] = 4'($urandom());
    m_wdata[32*m +: 32] = $urandom();
  endtask

  task automatic drive_masters();
    for (int m = 0; m < M; m++) begin
      if (m_req[m] && prev_ack[m]) begin
        if ($urandom_range(0, 2) == 0) m_req[m] = 1'b0;
        else new_req(m, pick_addr(), 1'($urandom_range(0, 1)));
      end else if (!m_req[m] && $urandom_range(0, 1) == 0) begin
        new_req(m, pick_addr(), 1'($urandom_range(0, 1)));
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_outputs();
    snap_m_ack = m_ack; snap_m_err = m_err; snap_m_rdata = m_rdata;
    snap_s_req = s_req; snap_s_abort = s_abort; snap_s_addr = s_addr; snap_s_we = s_we;
    chk("m_ack", m_ack, e_m_ack);
    chk("m_err", m_err, e_m_err);
    chk("m_rdata", m_rdata, e_m_rdata);
    chk("s_req", s_req, e_s_req);
    chk("s_addr", s_addr, e_s_addr);
    chk("s_we", s_we, e_s_we);
    chk("s_wmask", s_wmask, e_s_wmask);
    chk("s_wdata", s_wdata, e_s_wdata);
    chk("s_abort", s_abort, e_s_abort);
    prev_ack = e_m_ack;
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    drive_slaves();
    cycle();
  endtask

  task automatic drop_acked();
    m_req = m_req & ~snap_m_ack;
  endtask

  task automatic clear_all();
    m_req = '0; m_addr = '0; m_we = '0; m_wmask = '0; m_wdata = '0;
    for (int s = 0; s < S; s++) flat[s] = -1;
    spur_en = 1'b0; rd_fixed = 1'b0; rd_val = '0;
  endtask

  task automatic do_reset();
    clear_all();
    res = 1'b1;
    step();
    res = 1'b0;
  endtask

  initial begin
    int a0, a2, nacks;
    bit gap_due;
    int seq [$];
    res = 1'b1;
    s_ack = '0; s_rdata = '0; prev_ack = '0;
    clear_all();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    res = 1'b0;

    step();
    chk("reset_quiet", {snap_m_ack, snap_m_err, snap_s_req, snap_s_abort}, '0);

    // single read of RAM, slave answers two cycles after s_req
    do_reset();
    flat[5] = 2; rd_fixed = 1'b1; rd_val = 32'hDEAD_BEEF;
    new_req(0, 32'h1000_0000, 1'b0);
    step();
    chk("d1_sreq_late", snap_s_req, '0);
    step();
    chk("d1_sreq_rise", snap_s_req, 7'b010_0000);
    chk("d1_saddr", snap_s_addr[32*5 +: 32], 32'h1000_0000);
    step();
    chk("d1_wait_ack", snap_m_ack, '0);
    step();
    chk("d1_ack", snap_m_ack, 3'b001);
    chk("d1_err", snap_m_err, 3'b000);
    chk("d1_rdata", snap_m_rdata[31:0], 32'hDEAD_BEEF);
    drop_acked();
    step();

    // two masters hammering a zero-wait slave
    do_reset();
    flat[2] = 0;
    new_req(0, 32'h0200_0010, 1'b0);
    new_req(1, 32'h0200_0020, 1'b1);
    gap_due = 1'b0;
    seq.delete();
    for (int i = 0; i < 16; i++) begin
      step();
      if (gap_due) chk("d2_idle_gap", snap_s_req[2], 1'b0);
      gap_due = |snap_m_ack;
      if (snap_m_ack[0]) seq.push_back(0);
      if (snap_m_ack[1]) seq.push_back(1);
    end
    nacks = seq.size();
    chk("d2_ack_count", 32'(nacks), 32'd8);
    for (int k = 0; k < nacks; k++) chk("d2_alternate", 32'(seq[k]), 32'(k % 2));

    // parallel transfers to different slaves
    do_reset();
    flat[5] = 3; flat[2] = 1;
    new_req(0, 32'h1000_0010, 1'b0);
    new_req(2, 32'h0200_0004, 1'b1);
    a0 = -1; a2 = -1;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i == 2) chk("d3_parallel", {snap_s_req[5], snap_s_req[2]}, 2'b11);
      if (snap_m_ack[0]) a0 = i;
      if (snap_m_ack[2]) a2 = i;
      drop_acked();
    end
    chk("d3_ack_m2", 32'(a2), 32'd3);
    chk("d3_ack_m0", 32'(a0), 32'd5);

    // unmapped write
    do_reset();
    new_req(1, 32'hF000_0000, 1'b1);
    step();
    chk("d4_no_ack_yet", snap_m_ack, '0);
    step();
    chk("d4_ack", snap_m_ack, 3'b010);
    chk("d4_err", snap_m_err, 3'b010);
    chk("d4_rdata", snap_m_rdata, '0);
    chk("d4_no_sreq", snap_s_req, '0);
    m_req[1] = 1'b0;
    step();
    chk("d4_no_refire", snap_m_ack, '0);

    // timeout on a slave that never answers, then a late s_ack
    do_reset();
    flat[3] = 99;
    new_req(0, 32'h0300_0000, 1'b0);
    step();
    for (int i = 0; i < TO; i++) begin
      step();
      chk("d5_busy_sreq", {snap_s_req[3], snap_s_abort[3], snap_m_ack[0]}, 3'b100);
    end
    step();
    chk("d5_abort", snap_s_abort, 7'b000_1000);
    chk("d5_ack", snap_m_ack, 3'b001);
    chk("d5_err", snap_m_err, 3'b001);
    chk("d5_sreq_low", snap_s_req, '0);
    drop_acked();
    drive_slaves();
    s_ack[3] = 1'b1;
    cycle();
    chk("d5_late_ack", {snap_m_ack, snap_s_abort}, '0);

    // reset while busy, then rr pointer back at master 0
    do_reset();
    flat[5] = 99;
    new_req(0, 32'h1000_0100, 1'b0);
    step();
    step();
    new_req(1, 32'h1000_0200, 1'b0);
    res = 1'b1;
    step();
    res = 1'b0;
    step();
    chk("d6_quiet_ctl", {snap_m_ack, snap_m_err, snap_s_req, snap_s_abort, snap_s_we}, '0);
    chk("d6_quiet_rdata", snap_m_rdata, '0);
    chk("d6_quiet_saddr", snap_s_addr, '0);
    step();
    chk("d6_rr_reset", snap_s_addr[32*5 +: 32], 32'h1000_0100);
    m_req[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      drop_acked();
    end

    // random traffic
    do_reset();
    spur_en = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      drive_masters();
      res = ($urandom_range(0, 299) == 0);
      step();
    end
    res = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
